// File: rtl/am_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : am_pkg
//  Description : Shared types and default constants for the associative-memory
//                query controller and its serial argmax helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package am_pkg;

    // Controller states, shared so that observers can decode the state register.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_QUERY = 3'd1,
        S_INFER = 3'd2,
        S_TALLY = 3'd3,
        S_DONE  = 3'd4
    } am_state_t;

    localparam int DEFAULT_NUM_SEGMENTS = 4;
    localparam int DEFAULT_NUM_CLASSES  = 26;

endpackage : am_pkg
`default_nettype wire

// File: rtl/am_argmax_serial.sv
`default_nettype none
// ============================================================================
//  Module      : am_argmax_serial
//  Description : Walks class_sel across all classes, one class per step, and
//                tracks the index of the highest score seen. Ties keep the
//                lower index. best_idx already includes the compare of the
//                current step, so it is the final answer on the last step.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_argmax_serial #(
    parameter int NUM_CLASSES = 26,
    parameter int SCORE_W     = 16,
    parameter int CLASS_W     = $clog2(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               step,
    input  logic [SCORE_W-1:0] score,
    output logic [CLASS_W-1:0] class_sel,
    output logic [CLASS_W-1:0] best_idx,
    output logic               last
);

    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);

    logic [SCORE_W-1:0] best_score;
    logic [CLASS_W-1:0] best_idx_q;
    logic               take;

    // Class 0 always seeds the running maximum; later classes must beat it strictly.
    always_comb begin
        take     = (class_sel == '0) || (score > best_score);
        best_idx = take ? class_sel : best_idx_q;
        last     = (class_sel == LAST_CLASS);
    end

    // Running maximum and class walk; nothing moves unless start or step is given.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            class_sel  <= '0;
            best_score <= '0;
            best_idx_q <= '0;
        end else if (start) begin
            class_sel <= '0;
        end else if (step) begin
            if (take) begin
                best_score <= score;
                best_idx_q <= class_sel;
            end
            class_sel <= last ? '0 : class_sel + CLASS_W'(1);
        end
    end

endmodule : am_argmax_serial
`default_nettype wire

// File: rtl/am_query_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : am_query_ctrl
//  Description : Associative-memory query controller. Accepts NUM_SEGMENTS
//                query segments over a valid/ready handshake, runs a serial
//                argmax over NUM_CLASSES similarity scores, and keeps running
//                saturating accuracy counts over the test set.
//  Revision    : 1.0 - initial release
// ============================================================================
module am_query_ctrl
    import am_pkg::*;
#(
    parameter int NUM_SEGMENTS = DEFAULT_NUM_SEGMENTS,
    parameter int NUM_CLASSES  = DEFAULT_NUM_CLASSES,
    parameter int SCORE_W      = 16,
    parameter int COUNT_W      = 16,
    // Derived widths; leave at their defaults.
    parameter int SEG_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1,
    parameter int CLASS_W      = $clog2(NUM_CLASSES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start_querying,
    input  logic               testing_dataset_finished,
    input  logic               seg_valid,
    output logic               seg_ready,
    output logic [SEG_W-1:0]   query_ctr,
    output logic               comparing_query_hv_with_class_hv,
    output logic [CLASS_W-1:0] class_sel,
    input  logic [SCORE_W-1:0] class_score,
    output logic               inferring_class,
    input  logic [CLASS_W-1:0] label,
    output logic               tallying_accuracy,
    output logic [CLASS_W-1:0] predicted_class,
    output logic               pred_valid,
    output logic [COUNT_W-1:0] correct_count,
    output logic [COUNT_W-1:0] total_count,
    output logic               done
);

    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEGMENTS - 1);

    am_state_t          state;
    am_state_t          state_nxt;
    logic               seg_accept;
    logic               last_seg;
    logic               infer_start;
    logic               infer_step;
    logic               argmax_last;
    logic [CLASS_W-1:0] argmax_best;
    logic               clear_counts;

    // Handshake and sequencing strobes; all qualified by en so a stalled cycle changes nothing.
    always_comb begin
        last_seg     = (query_ctr == LAST_SEG);
        seg_accept   = seg_valid && seg_ready;
        infer_start  = seg_accept && last_seg;
        infer_step   = en && (state == S_INFER);
        clear_counts = en && start_querying && ((state == S_IDLE) || (state == S_DONE));
    end

    am_argmax_serial #(
        .NUM_CLASSES (NUM_CLASSES),
        .SCORE_W     (SCORE_W),
        .CLASS_W     (CLASS_W)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .start     (infer_start),
        .step      (infer_step),
        .score     (class_score),
        .class_sel (class_sel),
        .best_idx  (argmax_best),
        .last      (argmax_last)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start_querying is only honoured from IDLE and DONE.
    always_comb begin
        state_nxt = state;
        if (en) begin
            case (state)
                S_IDLE:  if (start_querying) state_nxt = S_QUERY;
                S_QUERY: if (infer_start)    state_nxt = S_INFER;
                S_INFER: if (argmax_last)    state_nxt = S_TALLY;
                S_TALLY: state_nxt = testing_dataset_finished ? S_DONE : S_QUERY;
                S_DONE:  if (start_querying) state_nxt = S_QUERY;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Control outputs decode the registered state; seg_ready and pred_valid also need en.
    always_comb begin
        seg_ready                        = 1'b0;
        comparing_query_hv_with_class_hv = 1'b0;
        inferring_class                  = 1'b0;
        tallying_accuracy                = 1'b0;
        pred_valid                       = 1'b0;
        done                             = 1'b0;
        case (state)
            S_QUERY: begin
                comparing_query_hv_with_class_hv = 1'b1;
                seg_ready                        = en;
            end
            S_INFER: inferring_class = 1'b1;
            S_TALLY: begin
                tallying_accuracy = 1'b1;
                pred_valid        = en;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Segment counter doubles as the demux select for the incoming segment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            query_ctr <= '0;
        end else if (seg_accept) begin
            query_ctr <= last_seg ? '0 : query_ctr + SEG_W'(1);
        end
    end

    // Capture the argmax winner on the final class step, including that step's compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            predicted_class <= '0;
        end else if (infer_step && argmax_last) begin
            predicted_class <= argmax_best;
        end
    end

    // Saturating accuracy tally, cleared whenever a new run starts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            correct_count <= '0;
            total_count   <= '0;
        end else if (clear_counts) begin
            correct_count <= '0;
            total_count   <= '0;
        end else if (pred_valid) begin
            if (total_count != '1) begin
                total_count <= total_count + COUNT_W'(1);
            end
            if ((predicted_class == label) && (correct_count != '1)) begin
                correct_count <= correct_count + COUNT_W'(1);
            end
        end
    end

endmodule : am_query_ctrl
`default_nettype wire

// File: tb/tb_am_query_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_am_query_ctrl
//  Description : Directed bench for am_query_ctrl with a scoreboard queue of
//                expected tally results and an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_am_query_ctrl;
    import am_pkg::*;

    localparam int NS = 4;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start_querying;
    logic        testing_dataset_finished;
    logic        seg_valid;
    logic        seg_ready;
    logic [1:0]  query_ctr;
    logic        comparing_query_hv_with_class_hv;
    logic [1:0]  class_sel;
    logic [15:0] class_score;
    logic        inferring_class;
    logic [1:0]  label;
    logic        tallying_accuracy;
    logic [1:0]  predicted_class;
    logic        pred_valid;
    logic [1:0]  correct_count;
    logic [1:0]  total_count;
    logic        done;

    logic [15:0] scores [NC];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic [1:0] pred;
        logic [1:0] corr;
        logic [1:0] tot;
        int         tally_cyc;
    } exp_t;
    exp_t sb[$];

    am_query_ctrl #(
        .NUM_SEGMENTS (NS),
        .NUM_CLASSES  (NC),
        .SCORE_W      (16),
        .COUNT_W      (2)
    ) dut (
        .clk                              (clk),
        .rst                              (rst),
        .en                               (en),
        .start_querying                   (start_querying),
        .testing_dataset_finished         (testing_dataset_finished),
        .seg_valid                        (seg_valid),
        .seg_ready                        (seg_ready),
        .query_ctr                        (query_ctr),
        .comparing_query_hv_with_class_hv (comparing_query_hv_with_class_hv),
        .class_sel                        (class_sel),
        .class_score                      (class_score),
        .inferring_class                  (inferring_class),
        .label                            (label),
        .tallying_accuracy                (tallying_accuracy),
        .predicted_class                  (predicted_class),
        .pred_valid                       (pred_valid),
        .correct_count                    (correct_count),
        .total_count                      (total_count),
        .done                             (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Score memory model: read combinationally at the selected class.
    assign class_score = scores[class_sel];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_query();
        int i;
        for (i = 0; i < 50; i++) begin
            if (comparing_query_hv_with_class_hv === 1'b1) break;
            @(negedge clk);
        end
        if (i == 50) chk("wait_query_timeout", 0, 1);
    endtask

    // One query: segments with an optional seg_valid gap, then INFER with an optional en gap.
    task automatic run_query(input logic [15:0] s0, input logic [15:0] s1,
                             input logic [15:0] s2, input logic [15:0] s3,
                             input int stall_after, input int stall_len,
                             input int en_at, input int en_len,
                             input logic [1:0] lbl, input logic fin,
                             input logic [1:0] ep, input logic [1:0] ec, input logic [1:0] et);
        int   nacc;
        int   stalled;
        int   sel;
        int   i;
        exp_t e;
        scores[0] = s0; scores[1] = s1; scores[2] = s2; scores[3] = s3;
        label = lbl;
        testing_dataset_finished = fin;
        wait_query();
        e.pred = ep; e.corr = ec; e.tot = et;
        e.tally_cyc = cyc + NS + NC + stall_len + en_len;
        sb.push_back(e);
        nacc = 0; stalled = 0;
        while (nacc < NS) begin
            chk("query_ctr", query_ctr, nacc);
            if (nacc == stall_after && stalled < stall_len) begin
                seg_valid = 1'b0;
                stalled++;
            end else begin
                seg_valid = 1'b1;
                nacc++;
            end
            @(negedge clk);
        end
        seg_valid = 1'b0;
        chk("infer_entry", inferring_class, 1);
        sel = 0; i = 0;
        while (sel < NC) begin
            chk("class_sel", class_sel, sel);
            if (i >= en_at && i < en_at + en_len) begin
                en = 1'b0;
            end else begin
                en = 1'b1;
                sel++;
            end
            i++;
            @(negedge clk);
        end
        en = 1'b1;
        chk("tally_state", tallying_accuracy, 1);
        @(negedge clk);
    endtask

    // Monitor: every prediction pulse is matched against the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && pred_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pred", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("predicted_class", predicted_class, e.pred);
                    chk("tally_latency", cyc, e.tally_cyc);
                    @(negedge clk);
                    chk("correct_count", correct_count, e.corr);
                    chk("total_count", total_count, e.tot);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; start_querying = 1'b0; testing_dataset_finished = 1'b0;
        seg_valid = 1'b0; label = '0;
        for (int k = 0; k < NC; k++) scores[k] = '0;
        repeat (2) @(negedge clk);
        chk("rst_query_ctr", query_ctr, 0);
        chk("rst_class_sel", class_sel, 0);
        chk("rst_predicted", predicted_class, 0);
        chk("rst_correct", correct_count, 0);
        chk("rst_total", total_count, 0);
        chk("rst_flags", {seg_ready, comparing_query_hv_with_class_hv, inferring_class,
                          tallying_accuracy, pred_valid, done}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", 32'(dut.state), 32'(S_IDLE));
        start_querying = 1'b1;
        @(negedge clk);
        start_querying = 1'b0;

        // Tie between classes 1 and 2 resolves to 1; label matches.
        run_query(16'd3, 16'd9, 16'd9, 16'd2, -1, 0, -1, 0, 2'd1, 1'b0, 2'd1, 2'd1, 2'd1);
        // Three-cycle seg_valid gap after two segments; wrong label.
        run_query(16'd5, 16'd1, 16'd7, 16'd7, 2, 3, -1, 0, 2'd0, 1'b0, 2'd2, 2'd1, 2'd2);
        // en low for two INFER cycles; last query of the run.
        run_query(16'd4, 16'd4, 16'd10, 16'd6, -1, 0, 2, 2, 2'd2, 1'b1, 2'd2, 2'd2, 2'd3);

        chk("done_high", done, 1);
        repeat (3) @(negedge clk);
        chk("done_hold", done, 1);
        chk("done_correct_hold", correct_count, 2);
        chk("done_total_hold", total_count, 3);
        chk("done_pred_hold", predicted_class, 2);
        start_querying = 1'b1;
        @(negedge clk);
        start_querying = 1'b0;
        chk("restart_correct_clr", correct_count, 0);
        chk("restart_total_clr", total_count, 0);
        chk("restart_query", comparing_query_hv_with_class_hv, 1);

        // Five correct predictions drive both 2-bit counters into saturation.
        for (int k = 1; k <= 5; k++) begin
            run_query(16'd1, 16'd2, 16'd3, 16'd20, -1, 0, -1, 0, 2'd3, (k == 5),
                      2'd3, 2'((k > 3) ? 3 : k), 2'((k > 3) ? 3 : k));
        end
        chk("sat_done", done, 1);

        // Asynchronous reset in the middle of segment collection.
        start_querying = 1'b1;
        @(negedge clk);
        start_querying = 1'b0;
        seg_valid = 1'b1;
        repeat (2) @(negedge clk);
        seg_valid = 1'b0;
        chk("pre_rst_query_ctr", query_ctr, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_query_ctr", query_ctr, 0);
        chk("async_predicted", predicted_class, 0);
        chk("async_counts", {correct_count, total_count}, 0);
        chk("async_flags", {seg_ready, comparing_query_hv_with_class_hv, inferring_class,
                            tallying_accuracy, pred_valid, done}, 0);
        chk("async_state", 32'(dut.state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'(dut.state), 32'(S_IDLE));
        chk("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_am_query_ctrl
`default_nettype wire

// File: doc/am_query_ctrl.md
Name: am_query_ctrl

Overview:
Parametrised associative-memory (AM) query controller for the HDC inference datapath.
- Sequences NUM_SEGMENTS query-HV segments against the class HVs, using a valid/ready handshake that allows upstream stalls.
- Performs a serial argmax over NUM_CLASSES similarity scores.
- Tallies prediction accuracy against the label over the whole test set.
- Sits between the encoder output buffer and the class-HV memory / similarity accumulators.

Parameters:
- NUM_SEGMENTS, 4: query-HV segments per query; must be >= 1.
- NUM_CLASSES, 26: number of class HVs; must be >= 2.
- SCORE_W, 16: unsigned similarity score width.
- COUNT_W, 16: width of the accuracy counters.
- SEG_W, max(1,$clog2(NUM_SEGMENTS)): derived; do not override.
- CLASS_W, $clog2(NUM_CLASSES): derived; do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- en  in  1  global enable; when 0 all state holds.
- start_querying  in  1  starts or restarts a test run.
- testing_dataset_finished  in  1  sampled in TALLY; high means the last query of the run.
- seg_valid  in  1  upstream query segment is available.
- seg_ready  out  1  controller accepts the segment.
- query_ctr  out  SEG_W  index of the current segment (demux select).
- comparing_query_hv_with_class_hv  out  1  high in S_QUERY.
- class_sel  out  CLASS_W  class index whose score is being read.
- class_score  in  SCORE_W  score of class_sel; read combinationally in the same cycle.
- inferring_class  out  1  high in S_INFER.
- label  in  CLASS_W  true class of the current query; sampled in TALLY.
- tallying_accuracy  out  1  high in S_TALLY.
- predicted_class  out  CLASS_W  registered argmax result.
- pred_valid  out  1  one-cycle pulse in the S_TALLY cycle.
- correct_count  out  COUNT_W  number of correct predictions.
- total_count  out  COUNT_W  number of queries tallied.
- done  out  1  high in S_DONE.

Behaviour:
- Reset (async, rst=1): state=S_IDLE. query_ctr, class_sel, predicted_class, best_score, correct_count and total_count are all 0. All 1-bit outputs are 0.
- en=0 in any state: state, counters, argmax registers and accuracy counters all hold. seg_ready=0. pred_valid=0. Other outputs keep decoding the held state.
- State S_IDLE:
  - start_querying&&en: clear correct_count/total_count, go to S_QUERY.
- State S_QUERY:
  - seg_ready = en.
  - A segment is accepted on seg_valid&&seg_ready.
  - Each accept with query_ctr<NUM_SEGMENTS-1 increments query_ctr.
  - An accept with query_ctr==NUM_SEGMENTS-1 sets query_ctr to 0, class_sel to 0, and goes to S_INFER.
  - No accept: hold, including query_ctr.
  - NUM_SEGMENTS=1: a single accept leaves S_QUERY.
- State S_INFER (NUM_CLASSES enabled cycles):
  - Each cycle compares class_score with best_score.
  - Load best_score/best_idx when class_sel==0 or class_score>best_score (strict, unsigned). Ties keep the lower index.
  - class_sel increments each cycle.
  - On class_sel==NUM_CLASSES-1: write the final best index (including this cycle's compare) to predicted_class, set class_sel to 0, go to S_TALLY.
- State S_TALLY (1 cycle):
  - pred_valid=1.
  - total_count += 1.
  - correct_count += 1 if predicted_class==label.
  - Both counters saturate at 2^COUNT_W-1.
  - Next state: S_DONE if testing_dataset_finished, else S_QUERY.
- State S_DONE:
  - done=1; counts and predicted_class hold.
  - start_querying&&en: clear counters, go to S_QUERY.
- start_querying in S_QUERY, S_INFER or S_TALLY is ignored.
- Latency per query: NUM_SEGMENTS accepted segments + NUM_CLASSES cycles + 1 cycle, with no stalls.
- Control outputs are combinational decodes of the registered state only. seg_ready also depends on en.
- An asynchronous rst mid-operation aborts immediately to the reset values.

Decomposition:
- Shared package am_pkg holds:
  - typedef enum logic [2:0] {S_IDLE, S_QUERY, S_INFER, S_TALLY, S_DONE} am_state_t.
  - Default constants for NUM_SEGMENTS and NUM_CLASSES.
- One sub-module, am_argmax_serial (params NUM_CLASSES, SCORE_W):
  - Inputs: start, step, score.
  - Outputs: class_sel, best_idx, last.
- The top-level keeps the FSM, the segment counter and the accuracy counters.

Test Plan:
1. NUM_SEGMENTS=4, NUM_CLASSES=4, seg_valid always 1; scores {3,9,9,2}; label=1 -> query_ctr 0,1,2,3. Then 4 INFER cycles, predicted_class=1 (tie to lower index). pred_valid pulse, correct_count=1, total_count=1.
2. seg_valid deasserted for 3 cycles after segment 1 -> query_ctr holds at 2, no early S_INFER entry, total latency grows by exactly 3.
3. en=0 for 2 cycles mid-S_INFER -> class_sel and best_score frozen; the argmax result matches the unstalled run.
4. Three queries with labels matching {yes,no,yes}, testing_dataset_finished=1 on the third TALLY -> done=1, correct_count=2, total_count=3. start_querying then clears both counts to 0.
5. COUNT_W=2, five correct queries -> total_count and correct_count saturate at 3.
6. rst pulse asserted asynchronously mid-S_QUERY with query_ctr=2 -> all outputs are at reset values before the next clk edge, and state is S_IDLE.
